// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register file, operand forwarding,
// immediate select and the ID/EX pipeline register feeding the ALU.
module operand_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_CNT = 8,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [3:0]        alu_op_in,
    input  logic              reg_we_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              fwd_ex_en,
    input  logic [ADDR_W-1:0] fwd_ex_addr,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [3:0]        alu_op_out,
    output logic [ADDR_W-1:0] rd_out,
    output logic              reg_we_out,
    output logic              ex_valid
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    logic [DATA_W-1:0] op_a_c;
    logic [DATA_W-1:0] op_b_c;
    logic [DATA_W-1:0] rs2_val_c;

    logic [DATA_W-1:0] a_q,      a_d;
    logic [DATA_W-1:0] b_q,      b_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [ADDR_W-1:0] rd_q,     rd_d;
    logic              reg_we_q, reg_we_d;
    logic              valid_q,  valid_d;

    // Source resolution: zero register, then EX forward, then WB bypass, then file.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] rs,
        input logic [DATA_W-1:0] rf_val,
        input logic              ex_en,
        input logic [ADDR_W-1:0] ex_addr,
        input logic [DATA_W-1:0] ex_data,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W-1:0] val;
        if (rs == '0) begin
            val = '0;
        end else if (ex_en && (ex_addr == rs)) begin
            val = ex_data;
        end else if (w_en && (w_addr == rs)) begin
            val = w_data;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    // Register file next state; R0 is pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != '0)) begin
            regs_d[wb_addr] = wb_data;
        end
        regs_d[0] = '0;
    end

    // Register file storage; writeback proceeds regardless of stall/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Operand A/B selection with forwarding and immediate mux.
    always_comb begin
        op_a_c    = resolve(rs1, regs_q[rs1], fwd_ex_en, fwd_ex_addr, fwd_ex_data,
                            wb_en, wb_addr, wb_data);
        rs2_val_c = resolve(rs2, regs_q[rs2], fwd_ex_en, fwd_ex_addr, fwd_ex_data,
                            wb_en, wb_addr, wb_data);
        op_b_c    = use_imm ? imm : rs2_val_c;
    end

    // ID/EX next state: flush clears, stall holds, otherwise load.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        alu_op_d = alu_op_q;
        rd_d     = rd_q;
        reg_we_d = reg_we_q;
        valid_d  = valid_q;
        if (flush) begin
            a_d      = '0;
            b_d      = '0;
            alu_op_d = '0;
            rd_d     = '0;
            reg_we_d = 1'b0;
            valid_d  = 1'b0;
        end else if (!stall) begin
            a_d      = op_a_c;
            b_d      = op_b_c;
            alu_op_d = alu_op_in;
            rd_d     = rd_in;
            reg_we_d = in_valid & reg_we_in;
            valid_d  = in_valid;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            alu_op_q <= '0;
            rd_q     <= '0;
            reg_we_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            alu_op_q <= alu_op_d;
            rd_q     <= rd_d;
            reg_we_q <= reg_we_d;
            valid_q  <= valid_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign alu_op_out = alu_op_q;
    assign rd_out     = rd_q;
    assign reg_we_out = reg_we_q;
    assign ex_valid   = valid_q;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus a randomized
// run against a behavioural model of the register file and ID/EX register.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  rs1, rs2, rd_in;
    logic [15:0] imm;
    logic        use_imm;
    logic [3:0]  alu_op_in;
    logic        reg_we_in;
    logic        stall, flush;
    logic        fwd_ex_en;
    logic [2:0]  fwd_ex_addr;
    logic [15:0] fwd_ex_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] a_out, b_out;
    logic [3:0]  alu_op_out;
    logic [2:0]  rd_out;
    logic        reg_we_out, ex_valid;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [15:0] m_rf [8];
    logic [15:0] e_a, e_b;
    logic [3:0]  e_op;
    logic [2:0]  e_rd;
    logic        e_we, e_valid, e_def;

    operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2),
        .rd_in(rd_in), .imm(imm), .use_imm(use_imm), .alu_op_in(alu_op_in),
        .reg_we_in(reg_we_in), .stall(stall), .flush(flush),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .a_out(a_out), .b_out(b_out), .alu_op_out(alu_op_out), .rd_out(rd_out),
        .reg_we_out(reg_we_out), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_read(input logic [2:0] rs);
        if (rs == 3'd0) return 16'h0;
        if (fwd_ex_en && fwd_ex_addr == rs) return fwd_ex_data;
        if (wb_en && wb_addr == rs) return wb_data;
        return m_rf[rs];
    endfunction

    task automatic idle();
        rst = 0; in_valid = 0; rs1 = 0; rs2 = 0; rd_in = 0; imm = 0; use_imm = 0;
        alu_op_in = 0; reg_we_in = 0; stall = 0; flush = 0;
        fwd_ex_en = 0; fwd_ex_addr = 0; fwd_ex_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    // Advance one clock, stepping the model with the inputs currently applied.
    task automatic tick();
        logic [15:0] oa, ob;
        oa = m_read(rs1);
        ob = use_imm ? imm : m_read(rs2);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
            e_a = 0; e_b = 0; e_op = 0; e_rd = 0; e_we = 0; e_valid = 0; e_def = 1;
        end else begin
            if (wb_en && wb_addr != 3'd0) m_rf[wb_addr] = wb_data;
            if (flush) begin
                e_a = 0; e_b = 0; e_op = 0; e_rd = 0; e_we = 0; e_valid = 0; e_def = 1;
            end else if (!stall) begin
                e_a = oa; e_b = ob; e_op = alu_op_in; e_rd = rd_in;
                e_valid = in_valid; e_we = in_valid & reg_we_in; e_def = in_valid;
            end
        end
        #1;
    endtask

    task automatic writeback(input logic [2:0] addr, input logic [15:0] data);
        idle(); wb_en = 1; wb_addr = addr; wb_data = data; tick();
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick();
        vectors++;
        if ({a_out, b_out, alu_op_out, rd_out, reg_we_out, ex_valid} !== 41'h0) begin
            miscompares++;
            $display("FAIL reset_init: a=%h b=%h op=%h rd=%h we=%b v=%b, want all 0",
                     a_out, b_out, alu_op_out, rd_out, reg_we_out, ex_valid);
        end
        for (int i = 1; i < 8; i++) writeback(3'(i), 16'h1000 + 16'(i));
        idle(); in_valid = 1; reg_we_in = 1; rd_in = 5; rs1 = 1; rs2 = 2; alu_op_in = 4'd7;
        tick();
        vectors++;
        if (ex_valid !== 1'b1 || a_out !== 16'h1001) begin
            miscompares++;
            $display("FAIL reset_preload: v=%b a=%h, want v=1 a=1001", ex_valid, a_out);
        end
        rst = 1; tick(); tick();
        vectors++;
        if ({a_out, b_out, alu_op_out, rd_out, reg_we_out, ex_valid} !== 41'h0) begin
            miscompares++;
            $display("FAIL reset_mid: a=%h b=%h op=%h rd=%h we=%b v=%b, want all 0",
                     a_out, b_out, alu_op_out, rd_out, reg_we_out, ex_valid);
        end
        for (int i = 1; i < 8; i++) begin
            idle(); in_valid = 1; rs1 = 3'(i); rs2 = 3'(i); tick();
            vectors++;
            if (a_out !== 16'h0 || b_out !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_rf R%0d: a=%h b=%h, want 0", i, a_out, b_out);
            end
        end
    endtask

    task automatic test_wb_read();
        writeback(3'd3, 16'h1234);
        idle(); in_valid = 1; rs1 = 3; rs2 = 3; tick();
        vectors++;
        if (a_out !== 16'h1234 || b_out !== 16'h1234 || ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wb_read: a=%h b=%h v=%b, want 1234 1234 1", a_out, b_out, ex_valid);
        end
    endtask

    task automatic test_priority();
        writeback(3'd2, 16'h0005);
        idle(); in_valid = 1; rs1 = 2;
        wb_en = 1; wb_addr = 2; wb_data = 16'h00AA;
        fwd_ex_en = 1; fwd_ex_addr = 2; fwd_ex_data = 16'h00FF;
        tick();
        vectors++;
        if (a_out !== 16'h00FF) begin
            miscompares++;
            $display("FAIL prio_ex: a=%h, want 00ff", a_out);
        end
        writeback(3'd2, 16'h0005);
        idle(); in_valid = 1; rs1 = 2; wb_en = 1; wb_addr = 2; wb_data = 16'h00AA;
        fwd_ex_addr = 2; fwd_ex_data = 16'h00FF;
        tick();
        vectors++;
        if (a_out !== 16'h00AA) begin
            miscompares++;
            $display("FAIL prio_wb: a=%h, want 00aa", a_out);
        end
        idle(); in_valid = 1; rs1 = 2; tick();
        vectors++;
        if (a_out !== 16'h00AA) begin
            miscompares++;
            $display("FAIL prio_rf: a=%h, want 00aa", a_out);
        end
    endtask

    task automatic test_r0();
        idle(); in_valid = 1; rs1 = 0; rs2 = 0;
        wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF;
        fwd_ex_en = 1; fwd_ex_addr = 0; fwd_ex_data = 16'hBEEF;
        tick();
        vectors++;
        if (a_out !== 16'h0 || b_out !== 16'h0) begin
            miscompares++;
            $display("FAIL r0_bypass: a=%h b=%h, want 0 0", a_out, b_out);
        end
        idle(); in_valid = 1; rs1 = 0; rs2 = 0; tick();
        vectors++;
        if (a_out !== 16'h0 || b_out !== 16'h0) begin
            miscompares++;
            $display("FAIL r0_write: a=%h b=%h, want 0 0", a_out, b_out);
        end
    endtask

    task automatic test_imm();
        writeback(3'd5, 16'h0007);
        idle(); in_valid = 1; use_imm = 1; imm = 16'hFFF8; rs1 = 5; rs2 = 5; alu_op_in = 4'd1;
        tick();
        vectors++;
        if (b_out !== 16'hFFF8 || alu_op_out !== 4'd1 || a_out !== 16'h0007) begin
            miscompares++;
            $display("FAIL imm: a=%h b=%h op=%h, want 0007 fff8 1", a_out, b_out, alu_op_out);
        end
    endtask

    task automatic test_stall_flush();
        writeback(3'd1, 16'h0A0A);
        idle(); in_valid = 1; rs1 = 1; rs2 = 3; rd_in = 4; reg_we_in = 1; alu_op_in = 4'd3;
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(); stall = 1; in_valid = 1; rs1 = 5; rs2 = 2; rd_in = 6; reg_we_in = 0;
            alu_op_in = 4'd9; use_imm = 1; imm = 16'h5555;
            wb_en = (c == 1); wb_addr = 6; wb_data = 16'h6666;
            tick();
            vectors++;
            if (a_out !== 16'h0A0A || b_out !== 16'h1234 || rd_out !== 3'd4 ||
                alu_op_out !== 4'd3 || reg_we_out !== 1'b1 || ex_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold%0d: a=%h b=%h rd=%h op=%h we=%b v=%b, want 0a0a 1234 4 3 1 1",
                         c, a_out, b_out, rd_out, alu_op_out, reg_we_out, ex_valid);
            end
        end
        idle(); stall = 1; flush = 1; in_valid = 1; reg_we_in = 1; rs1 = 1; rd_in = 2;
        tick();
        vectors++;
        if ({a_out, b_out, alu_op_out, rd_out, reg_we_out, ex_valid} !== 41'h0) begin
            miscompares++;
            $display("FAIL flush: a=%h b=%h op=%h rd=%h we=%b v=%b, want all 0",
                     a_out, b_out, alu_op_out, rd_out, reg_we_out, ex_valid);
        end
        idle(); in_valid = 1; rs1 = 6; tick();
        vectors++;
        if (a_out !== 16'h6666) begin
            miscompares++;
            $display("FAIL stall_wb: a=%h, want 6666", a_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            stall       = ($urandom_range(0, 5) == 0);
            in_valid    = 1'($urandom);
            rs1         = 3'($urandom);
            rs2         = 3'($urandom);
            rd_in       = 3'($urandom);
            imm         = 16'($urandom);
            use_imm     = 1'($urandom);
            alu_op_in   = 4'($urandom);
            reg_we_in   = 1'($urandom);
            fwd_ex_en   = 1'($urandom);
            fwd_ex_addr = 3'($urandom);
            fwd_ex_data = 16'($urandom);
            wb_en       = 1'($urandom);
            wb_addr     = 3'($urandom);
            wb_data     = 16'($urandom);
            tick();
            vectors++;
            if (ex_valid !== e_valid || reg_we_out !== e_we ||
                (e_def && (a_out !== e_a || b_out !== e_b ||
                           alu_op_out !== e_op || rd_out !== e_rd))) begin
                miscompares++;
                $display("FAIL random[%0d]: a=%h b=%h op=%h rd=%h we=%b v=%b, want %h %h %h %h %b %b",
                         n, a_out, b_out, alu_op_out, rd_out, reg_we_out, ex_valid,
                         e_a, e_b, e_op, e_rd, e_we, e_valid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        e_a = 0; e_b = 0; e_op = 0; e_rd = 0; e_we = 0; e_valid = 0; e_def = 0;
        idle();
        #1;
        test_reset();
        test_wb_read();
        test_priority();
        test_r0();
        test_imm();
        test_stall_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
